// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the sequential multiplier
//
// Purpose: state encoding and datapath sizing shared by seq_mult32 and its helpers.
package seq_mult_pkg;

  localparam int WIDTH    = 32;
  localparam int ACC_W    = 2 * WIDTH;
  localparam int ITER_MAX = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cond_neg.sv
// rtl/cond_neg.sv - conditional two's-complement negate
//
// Purpose: returns -i_val when i_neg is set, else i_val (modulo 2^W).
// Ports:
//   i_val  W-bit operand
//   i_neg  negate select
//   o_val  W-bit result
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/seq_mult32.sv
// rtl/seq_mult32.sv - multi-cycle signed 32x32 shift-and-add multiplier
//
// Purpose: sign-magnitude shift-and-add multiply; returns the low word of the
// signed product, a one-cycle ready pulse and an overflow exception.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN (stop iterating once the
// remaining multiplier bits are all zero).
// Ports:
//   clock           clock, rising edge
//   reset           synchronous active-high reset
//   ctrl_MULT       start strobe, operands sampled on this edge
//   data_operandA   multiplicand (two's complement)
//   data_operandB   multiplier (two's complement)
//   data_result     low 32 bits of product, held until next FIX
//   data_resultRDY  one-cycle valid pulse
//   data_exception  product does not fit in 32 signed bits
//   busy            operation in flight (start edge until RDY drops)
module seq_mult32
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int LACC_W = 2 * WIDTH;

  state_t              r_state;
  logic [LACC_W-1:0]   r_acc;
  logic [LACC_W-1:0]   r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_sign;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_result;
  logic                r_rdy;
  logic                r_exc;
  logic                r_busy;

  logic [WIDTH-1:0]    w_mag_a;
  logic [WIDTH-1:0]    w_mag_b;
  logic [LACC_W-1:0]   w_prod;
  logic [LACC_W-1:0]   w_acc_next;
  logic [WIDTH-1:0]    w_mplier_shr;
  logic                w_cnt_last;
  logic                w_run_exit;
  logic                w_ovf;

  // Magnitudes as unsigned: negating 0x80000000 yields 0x80000000 = 2^31.
  cond_neg #(.W(WIDTH)) u_mag_a (
    .i_val (data_operandA),
    .i_neg (data_operandA[WIDTH-1]),
    .o_val (w_mag_a)
  );

  cond_neg #(.W(WIDTH)) u_mag_b (
    .i_val (data_operandB),
    .i_neg (data_operandB[WIDTH-1]),
    .o_val (w_mag_b)
  );

  // Sign is reapplied to the full 64-bit magnitude so overflow can be judged.
  cond_neg #(.W(LACC_W)) u_prod (
    .i_val (r_acc),
    .i_neg (r_sign),
    .o_val (w_prod)
  );

  assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_cnt_last   = (r_cnt == CNT_W'(ITER_MAX - 1));

`ifdef SEQ_MULT_EARLY_TERM_EN
  // No set bits left means no further partial products can contribute.
  assign w_run_exit = w_cnt_last || (w_mplier_shr == '0);
`else
  assign w_run_exit = w_cnt_last;
`endif

  // Fits in 32 signed bits only when bits [63:31] are a pure sign extension.
  assign w_ovf = ~((&w_prod[LACC_W-1:WIDTH-1]) | ~(|w_prod[LACC_W-1:WIDTH-1]));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_exc    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT) begin
        // A start in any state (re)launches; an aborted run never reaches FIX.
        r_state  <= RUN;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          RUN: begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + 1'b1;
            if (w_run_exit) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            r_result <= w_prod[WIDTH-1:0];
            r_exc    <= w_ovf;
            r_rdy    <= 1'b1;
            r_state  <= DONE;
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = r_rdy;
  assign data_exception = r_exc;
  assign busy           = r_busy;

endmodule
